// File: rtl/risc_spm.sv
// risc_spm: 8-bit stored-program CPU with four registers, a zero flag and an
// internal 256x8 RAM. The controller is a single registered FSM; there is no external I/O.

module risc_spm_sram #(
  parameter int word_size = 8
) (
  input  logic                 clk,
  input  logic                 we_i,
  input  logic [word_size-1:0] addr_i,
  input  logic [word_size-1:0] wdata_i,
  output logic [word_size-1:0] rdata_o
);
  logic [word_size-1:0] memory [0:255];

  always_ff @(posedge clk) begin
    if (we_i) memory[addr_i] <= wdata_i;
  end

  assign rdata_o = memory[addr_i];
endmodule

module risc_spm #(
  parameter int word_size = 8
) (
  input logic clk,
  input logic rst
);
  typedef enum logic [3:0] {
    S_idle, S_fet1, S_fet2, S_dec, S_ex1, S_rd1, S_rd2,
    S_wr1, S_wr2, S_br1, S_br2, S_halt
  } state_t;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_NOT = 4'd4;
  localparam logic [3:0] OP_RD  = 4'd5;
  localparam logic [3:0] OP_WR  = 4'd6;
  localparam logic [3:0] OP_BR  = 4'd7;
  localparam logic [3:0] OP_BRZ = 4'd8;

  state_t               state_q;
  logic [word_size-1:0] r_q [0:3];
  logic [word_size-1:0] pc_q, ir_q, add_r_q, y_q;
  logic                 z_q;

  logic [3:0]           opcode;
  logic [1:0]           src, dest;
  logic [word_size-1:0] bus_1, mem_word, alu_res;
  logic                 mem_we;

  assign opcode = ir_q[7:4];
  assign src    = ir_q[3:2];
  assign dest   = ir_q[1:0];
  assign bus_1  = r_q[src];
  assign mem_we = (state_q == S_wr2);

  risc_spm_sram #(.word_size(word_size)) M2_SRAM (
    .clk     (clk),
    .we_i    (mem_we),
    .addr_i  (add_r_q),
    .wdata_i (bus_1),
    .rdata_o (mem_word)
  );

  // Y holds the source operand latched in S_dec; the destination is read live in S_ex1.
  always_comb begin
    alu_res = '0;
    case (opcode)
      OP_ADD:  alu_res = r_q[dest] + y_q;
      OP_SUB:  alu_res = r_q[dest] - y_q;
      OP_AND:  alu_res = r_q[dest] & y_q;
      OP_NOT:  alu_res = ~bus_1;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_idle;
      pc_q    <= '0;
      ir_q    <= '0;
      add_r_q <= '0;
      y_q     <= '0;
      z_q     <= 1'b0;
      for (int i = 0; i < 4; i++) r_q[i] <= '0;
    end else begin
      case (state_q)
        S_idle: state_q <= S_fet1;
        S_fet1: begin
          add_r_q <= pc_q;
          state_q <= S_fet2;
        end
        S_fet2: begin
          ir_q    <= mem_word;
          pc_q    <= pc_q + 8'd1;
          state_q <= S_dec;
        end
        S_dec: begin
          case (opcode)
            OP_NOP: state_q <= S_fet1;
            OP_ADD, OP_SUB, OP_AND: begin
              y_q     <= bus_1;
              state_q <= S_ex1;
            end
            OP_NOT: begin
              r_q[dest] <= alu_res;
              z_q       <= (alu_res == '0);
              state_q   <= S_fet1;
            end
            OP_RD: begin
              add_r_q <= pc_q;
              state_q <= S_rd1;
            end
            OP_WR: begin
              add_r_q <= pc_q;
              state_q <= S_wr1;
            end
            OP_BR: begin
              add_r_q <= pc_q;
              state_q <= S_br1;
            end
            OP_BRZ: begin
              if (z_q) begin
                add_r_q <= pc_q;
                state_q <= S_br1;
              end else begin
                pc_q    <= pc_q + 8'd1;
                state_q <= S_fet1;
              end
            end
            default: state_q <= S_halt;
          endcase
        end
        S_ex1: begin
          r_q[dest] <= alu_res;
          z_q       <= (alu_res == '0);
          state_q   <= S_fet1;
        end
        S_rd1: begin
          add_r_q <= mem_word;
          pc_q    <= pc_q + 8'd1;
          state_q <= S_rd2;
        end
        S_rd2: begin
          r_q[dest] <= mem_word;
          state_q   <= S_fet1;
        end
        S_wr1: begin
          add_r_q <= mem_word;
          pc_q    <= pc_q + 8'd1;
          state_q <= S_wr2;
        end
        S_wr2:  state_q <= S_fet1;
        S_br1: begin
          add_r_q <= mem_word;
          state_q <= S_br2;
        end
        S_br2: begin
          pc_q    <= mem_word;
          state_q <= S_fet1;
        end
        S_halt:  state_q <= S_halt;
        default: state_q <= S_idle;
      endcase
    end
  end
endmodule

// File: tb/tb_risc_spm.sv
// Bench for risc_spm: an instruction-level reference model is stepped in lockstep with the
// CPU, and architectural state is compared at every instruction boundary.

module tb_risc_spm;
  logic clk = 1'b0;
  logic rst = 1'b0;

  risc_spm dut (.clk(clk), .rst(rst));

  always #10 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] mm [256];
  logic [7:0] mr [4];
  logic [7:0] mpc, mir;
  logic       mz;
  bit         mhalt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic poke(input int a, input logic [7:0] v);
    dut.M2_SRAM.memory[a] = v;
    mm[a] = v;
  endtask

  task automatic clear_mem();
    for (int j = 0; j < 256; j++) poke(j, 8'h00);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) mr[i] = 8'h00;
    mpc = 8'h00; mir = 8'h00; mz = 1'b0; mhalt = 1'b0;
  endfunction

  function automatic int cycles_of();
    logic [3:0] op;
    op = mm[mpc][7:4];
    if (op == 4'd0 || op == 4'd4) return 3;
    if (op >= 4'd1 && op <= 4'd3) return 4;
    if (op >= 4'd5 && op <= 4'd7) return 5;
    if (op == 4'd8) return mz ? 5 : 3;
    return 3;
  endfunction

  function automatic void model_exec();
    logic [7:0] a, res;
    logic [3:0] op;
    logic [1:0] s, d;
    mir = mm[mpc];
    mpc = mpc + 8'd1;
    op = mir[7:4]; s = mir[3:2]; d = mir[1:0];
    case (op)
      4'd0: ;
      4'd1, 4'd2, 4'd3, 4'd4: begin
        case (op)
          4'd1:    res = mr[d] + mr[s];
          4'd2:    res = mr[d] - mr[s];
          4'd3:    res = mr[d] & mr[s];
          default: res = ~mr[s];
        endcase
        mr[d] = res;
        mz = (res == 8'h00);
      end
      4'd5: begin a = mm[mpc]; mpc = mpc + 8'd1; mr[d] = mm[a]; end
      4'd6: begin a = mm[mpc]; mpc = mpc + 8'd1; mm[a] = mr[s]; end
      4'd7: mpc = mm[mm[mpc]];
      4'd8: if (mz) mpc = mm[mm[mpc]]; else mpc = mpc + 8'd1;
      default: mhalt = 1'b1;
    endcase
  endfunction

  task automatic compare_state(input string tag);
    int bad;
    chk({tag, ".pc"}, dut.pc_q, mpc);
    chk({tag, ".ir"}, dut.ir_q, mir);
    chk({tag, ".z"},  dut.z_q,  mz);
    for (int i = 0; i < 4; i++) chk($sformatf("%s.r%0d", tag, i), dut.r_q[i], mr[i]);
    bad = 0;
    for (int j = 0; j < 256; j++) if (dut.M2_SRAM.memory[j] !== mm[j]) bad++;
    chk({tag, ".mem_diff_bytes"}, bad, 0);
  endtask

  // Entered with rst low; leaves rst low after an abort, high otherwise.
  task automatic run(input string tag, input int max_instr, input int abort_at);
    int n, k;
    model_reset();
    @(negedge clk);
    compare_state({tag, ".reset"});
    rst = 1'b1;
    @(posedge clk);
    for (int i = 0; i < max_instr && !mhalt; i++) begin
      n = cycles_of();
      if (i == abort_at) begin
        k = $urandom_range(1, n - 1);
        repeat (k) @(posedge clk);
        #3 rst = 1'b0;
        #1 model_reset();
        compare_state({tag, ".abort"});
        $display("%s: reset asserted %0d cycles into instruction %0d", tag, k, i);
        return;
      end
      repeat (n) @(posedge clk);
      #1 model_exec();
      compare_state($sformatf("%s.i%0d", tag, i));
    end
    if (mhalt) begin
      repeat (25) @(posedge clk);
      #1 compare_state({tag, ".halted"});
    end
    $display("%s: pc=%0d r0=%0h r1=%0h r2=%0h r3=%0h z=%0b halt=%0b",
             tag, mpc, mr[0], mr[1], mr[2], mr[3], mz, mhalt);
  endtask

  task automatic load_loop();
    logic [7:0] prog [15];
    prog = '{8'h00, 8'h52, 8'd130, 8'h53, 8'd131, 8'h51, 8'd128, 8'h50, 8'd129,
             8'h21, 8'h80, 8'd134, 8'h1B, 8'h73, 8'd140};
    clear_mem();
    for (int j = 0; j < 15; j++) poke(j, prog[j]);
    poke(128, 8'd6); poke(129, 8'd1); poke(130, 8'd2); poke(131, 8'd0);
    poke(134, 8'd139); poke(139, 8'hF0); poke(140, 8'd9);
  endtask

  initial begin
    logic [3:0] op, lo;
    int abort_at;

    // Loop program from the test plan.
    load_loop();
    run("loop", 400, -1);
    chk("loop.pc_lit", dut.pc_q, 8'd140);
    chk("loop.r0_lit", dut.r_q[0], 8'd1);
    chk("loop.r1_lit", dut.r_q[1], 8'd0);
    chk("loop.r2_lit", dut.r_q[2], 8'd2);
    chk("loop.r3_lit", dut.r_q[3], 8'd10);
    chk("loop.m131_lit", dut.M2_SRAM.memory[131], 8'd0);
    chk("loop.m140_lit", dut.M2_SRAM.memory[140], 8'd9);
    rst = 1'b0; #5;

    // Exit redirected to WR R3,[131] then HALT.
    poke(134, 8'd141); poke(141, 8'h6C); poke(142, 8'd131); poke(143, 8'hF0);
    run("loopwr", 400, -1);
    chk("loopwr.m131_lit", dut.M2_SRAM.memory[131], 8'd10);
    chk("loopwr.pc_lit", dut.pc_q, 8'd144);
    rst = 1'b0; #5;

    // Reset in the middle of the fourth instruction (an RD), then rerun from 0.
    load_loop();
    run("rdabort", 400, 3);
    chk("rdabort.pc_lit", dut.pc_q, 8'd0);
    chk("rdabort.r2_lit", dut.r_q[2], 8'd0);
    run("rerun", 400, -1);
    chk("rerun.r3_lit", dut.r_q[3], 8'd10);
    rst = 1'b0; #5;

    // ADD wrap to zero, BRZ taken, NOT, BRZ not taken, AND to zero.
    clear_mem();
    poke(0, 8'h50); poke(1, 8'd200); poke(2, 8'h51); poke(3, 8'd201);
    poke(4, 8'h11); poke(5, 8'h80); poke(6, 8'd202);
    poke(20, 8'h50); poke(21, 8'd203); poke(22, 8'h42);
    poke(23, 8'h80); poke(24, 8'd202); poke(25, 8'h38); poke(26, 8'hF0);
    poke(200, 8'hFF); poke(201, 8'h01); poke(202, 8'd20); poke(203, 8'h0F);
    run("alu", 100, -1);
    chk("alu.pc_lit", dut.pc_q, 8'd27);
    chk("alu.r0_lit", dut.r_q[0], 8'h00);
    chk("alu.r1_lit", dut.r_q[1], 8'h00);
    chk("alu.r2_lit", dut.r_q[2], 8'hF0);
    chk("alu.z_lit", dut.z_q, 1'b1);
    rst = 1'b0; #5;

    // Illegal opcode halts with PC frozen.
    clear_mem();
    poke(0, 8'hA0);
    run("illegal", 10, -1);
    repeat (60) @(posedge clk);
    #1 chk("illegal.pc_lit", dut.pc_q, 8'd1);
    chk("illegal.ir_lit", dut.ir_q, 8'hA0);
    rst = 1'b0; #5;

    // Random programs, some with a reset dropped into a random instruction.
    for (int t = 0; t < 24; t++) begin
      for (int j = 0; j < 256; j++) begin
        if ($urandom_range(0, 99) < 4) op = 4'($urandom_range(9, 15));
        else                           op = 4'($urandom_range(0, 8));
        lo = 4'($urandom);
        poke(j, {op, lo});
      end
      abort_at = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 30) : -1;
      run($sformatf("rand%0d", t), 60, abort_at);
      if (abort_at >= 0 && rst) begin
        rst = 1'b0;
      end else if (abort_at >= 0) begin
        run($sformatf("rand%0d.rerun", t), 60, -1);
        rst = 1'b0;
      end
      rst = 1'b0; #5;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
